// File: rtl/nrisc_ddata_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nrisc_ddata_bridge_pkg
// Brief    : Shared encodings for the NRISC D-Data byte-serialising bridge:
//            size codes, control bit index, FSM states, beat-count helper.
// Revision : 1.0 - initial release
// ============================================================================
package nrisc_ddata_bridge_pkg;

  // core_ctrl[1:0] size encodings
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_FULL = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // core_ctrl bit selecting sign extension of load results
  localparam int CTRL_SIGN = 2;

  // Bridge FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_RTAIL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Number of byte beats for a size code; a full word is full_bytes wide,
  // so with a 16-bit core SZ_FULL collapses onto SZ_HALF.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz, input int full_bytes);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'(full_bytes);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/nrisc_ddata_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : nrisc_ddata_core_if / nrisc_ddata_mem_if
// Brief    : Core-side request bus and byte-wide memory bus of the D-Data
//            bridge. master = initiator of the bus, slave = responder.
// Revision : 1.0 - initial release
// ============================================================================
interface nrisc_ddata_core_if #(
  parameter int TAM     = 16,
  parameter int N_DData = 16
);
  logic [N_DData-1:0] core_addr;
  logic [TAM-1:0]     core_wdata;
  logic               core_load;
  logic               core_write;
  logic [2:0]         core_ctrl;
  logic               core_busy;
  logic               core_done;
  logic               core_err;
  logic [TAM-1:0]     core_rdata;

  // The NRISC core issues requests
  modport master (
    output core_addr, core_wdata, core_load, core_write, core_ctrl,
    input  core_busy, core_done, core_err, core_rdata
  );

  // The bridge serves them
  modport slave (
    input  core_addr, core_wdata, core_load, core_write, core_ctrl,
    output core_busy, core_done, core_err, core_rdata
  );
endinterface

interface nrisc_ddata_mem_if #(
  parameter int N_DData = 16
);
  logic [N_DData-1:0] mem_addr;
  logic [7:0]         mem_wdata;
  logic               mem_en;
  logic               mem_we;
  logic               mem_ready;
  logic [7:0]         mem_rdata;

  // The bridge issues byte beats
  modport master (
    output mem_addr, mem_wdata, mem_en, mem_we,
    input  mem_ready, mem_rdata
  );

  // The memory accepts them
  modport slave (
    input  mem_addr, mem_wdata, mem_en, mem_we,
    output mem_ready, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/nrisc_ddata_extend.sv
`default_nettype none
// ============================================================================
// Module   : nrisc_ddata_extend
// Brief    : Combinational lane assembler: keeps the loaded low bytes and
//            fills the rest of the word with the top loaded bit or zero.
// Revision : 1.0 - initial release
// ============================================================================
module nrisc_ddata_extend
  import nrisc_ddata_bridge_pkg::*;
#(
  parameter int TAM = 16
) (
  input  logic [TAM-1:0] lanes,
  input  logic [1:0]     size,
  input  logic           sign,
  output logic [TAM-1:0] word
);

  logic [2:0] w_nbytes;
  logic       w_top;
  logic       w_fill;

  // Find the top loaded bit, then replace every bit above the loaded bytes
  always_comb begin
    w_nbytes = size_bytes(size, TAM / 8);
    case (w_nbytes)
      3'd1:    w_top = lanes[7];
      3'd2:    w_top = lanes[15];
      default: w_top = lanes[TAM-1];
    endcase
    w_fill = sign & w_top;
    word   = '0;
    for (int i = 0; i < TAM; i++) begin
      word[i] = (i < 8 * int'(w_nbytes)) ? lanes[i] : w_fill;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nrisc_ddata_bridge.sv
`default_nettype none
// ============================================================================
// Module   : nrisc_ddata_bridge
// Brief    : Turns one core load/store into little-endian byte beats on an
//            8-bit ready-handshaked memory bus and returns extended loads.
// Revision : 1.0 - initial release
// ============================================================================
module nrisc_ddata_bridge
  import nrisc_ddata_bridge_pkg::*;
#(
  parameter int TAM     = 16,
  parameter int N_DData = 16
) (
  input  logic              clk,
  input  logic              rst,
  nrisc_ddata_core_if.slave core,
  nrisc_ddata_mem_if.master mem
);

  localparam int NB_FULL = TAM / 8;

  if (TAM != 16 && TAM != 32) begin : g_tam_check
    $error("nrisc_ddata_bridge: TAM must be 16 or 32");
  end

  state_t             r_state, w_state_nxt;
  logic [N_DData-1:0] r_base;
  logic [TAM-1:0]     r_wdata;
  logic [1:0]         r_size;
  logic               r_sign;
  logic               r_we;
  logic [2:0]         r_nbytes;
  logic [2:0]         r_cnt;
  logic               r_pend;
  logic [1:0]         r_pend_lane;
  logic [TAM-1:0]     r_lanes;
  logic [TAM-1:0]     r_rdata;
  logic               r_err;

  logic               w_strobe;
  logic               w_accept;
  logic               w_reject;
  logic               w_xfer;
  logic               w_done;
  logic               w_beat;
  logic               w_last;
  logic [TAM-1:0]     w_lanes_nxt;
  logic [TAM-1:0]     w_ext;
  logic [TAM-1:0]     w_wshift;

  // Requests are only looked at while idle; anything arriving while busy is dropped
  assign w_strobe = core.core_load | core.core_write;
  assign w_accept = (r_state == S_IDLE) & (core.core_load ^ core.core_write)
                  & (core.core_ctrl[1:0] != SZ_RSVD);
  assign w_reject = (r_state == S_IDLE) & w_strobe & ~w_accept;

  assign w_beat   = w_xfer & mem.mem_ready;
  assign w_last   = (r_cnt == r_nbytes - 3'd1);
  assign w_wshift = r_wdata >> {r_cnt, 3'b000};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and state-decoded strobes
  always_comb begin
    w_state_nxt = r_state;
    w_xfer      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_XFER;
      end
      S_XFER: begin
        w_xfer = 1'b1;
        if (w_beat && w_last) w_state_nxt = r_we ? S_DONE : S_RTAIL;
      end
      S_RTAIL: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch and beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base   <= '0;
      r_wdata  <= '0;
      r_size   <= SZ_BYTE;
      r_sign   <= 1'b0;
      r_we     <= 1'b0;
      r_nbytes <= 3'd0;
      r_cnt    <= 3'd0;
    end else if (w_accept) begin
      r_base   <= core.core_addr;
      r_wdata  <= core.core_wdata;
      r_size   <= core.core_ctrl[1:0];
      r_sign   <= core.core_ctrl[CTRL_SIGN];
      r_we     <= core.core_write;
      r_nbytes <= size_bytes(core.core_ctrl[1:0], NB_FULL);
      r_cnt    <= 3'd0;
    end else if (w_beat) begin
      r_cnt    <= r_cnt + 3'd1;
    end
  end

  // Read byte arrives one cycle after its beat; merge it into its lane combinationally
  always_comb begin
    w_lanes_nxt = r_lanes;
    if (r_pend) begin
      for (int i = 0; i < NB_FULL; i++) begin
        if (r_pend_lane == 2'(i)) w_lanes_nxt[8*i +: 8] = mem.mem_rdata;
      end
    end
  end

  // Capture register: remembers which lane is due and stores arriving bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_pend_lane <= 2'd0;
      r_lanes     <= '0;
    end else begin
      r_pend      <= w_beat & ~r_we;
      r_pend_lane <= r_cnt[1:0];
      r_lanes     <= w_accept ? '0 : w_lanes_nxt;
    end
  end

  nrisc_ddata_extend #(
    .TAM (TAM)
  ) u_extend (
    .lanes (w_lanes_nxt),
    .size  (r_size),
    .sign  (r_sign),
    .word  (w_ext)
  );

  // Load result is registered as the final byte lands so it is valid during DONE
  always_ff @(posedge clk) begin
    if (rst)                     r_rdata <= '0;
    else if (r_state == S_RTAIL) r_rdata <= w_ext;
  end

  // Rejection pulse for the cycle after a bad request is sampled
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_reject;
  end

  assign core.core_busy  = (r_state != S_IDLE);
  assign core.core_done  = w_done;
  assign core.core_err   = r_err;
  assign core.core_rdata = r_rdata;

  assign mem.mem_en    = w_xfer;
  assign mem.mem_we    = w_xfer & r_we;
  assign mem.mem_addr  = w_xfer ? (r_base + N_DData'(r_cnt)) : '0;
  assign mem.mem_wdata = w_xfer ? w_wshift[7:0] : 8'h00;

endmodule
`default_nettype wire
